// File: rtl/miner_io_wrapper_pkg.sv
// miner_io_wrapper_pkg: glyph table, display source selects and UART state encodings
package miner_io_wrapper_pkg;
  localparam logic [15:0][7:0] SEG_LUT = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };
  localparam logic [2:0] DISP_NONCE   = 3'd0;
  localparam logic [2:0] DISP_TARGET  = 3'd1;
  localparam logic [2:0] DISP_RX_WORD = 3'd2;
  localparam logic [2:0] DISP_RESULT  = 3'd3;
  localparam logic [2:0] DISP_COUNTS  = 3'd4;
  localparam logic [2:0] DISP_STATUS  = 3'd5;
  localparam logic [2:0] DISP_ZERO    = 3'd6;
  typedef enum logic [2:0] {RX_UNARMED, RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
endpackage

// File: rtl/miner_io_wrapper_seg_mux.sv
// seg_mux: scans eight hex digits of a 32-bit value onto active-low anodes and cathodes
module seg_mux
  import miner_io_wrapper_pkg::*;
#(
  parameter int REFRESH_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value_i,
  output logic [7:0]  ca_o,
  output logic [7:0]  an_o
);
  localparam int CW = $clog2(REFRESH_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(REFRESH_CYCLES - 1);
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  always_ff @(posedge clk)
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_q == LAST ? '0 : cnt_q + 1'b1;
      idx_q <= cnt_q == LAST ? idx_q + 1'b1 : idx_q;
    end
  assign an_o = ~(8'b1 << idx_q);
  assign ca_o = SEG_LUT[value_i[{idx_q, 2'b00} +: 4]] | 8'h80;
endmodule

// File: rtl/miner_io_wrapper_uart_rx.sv
// uart_rx: 8N1 receiver that arms only after a full idle bit and drops framing errors
module uart_rx
  import miner_io_wrapper_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd_i,
  output logic [7:0] data_o,
  output logic       valid_o
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID = CW'((CLKS_PER_BIT - 1) / 2);
  rx_state_e     state_q;
  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    sh_q;
  logic          rxd_s;
  assign rxd_s = sync_q[1];
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= RX_UNARMED;
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      data_o  <= '0;
      valid_o <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rxd_i};
      valid_o <= 1'b0;
      case (state_q)
        RX_UNARMED: begin
          cnt_q <= rxd_s ? cnt_q + 1'b1 : '0;
          if (rxd_s && cnt_q == LAST) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
          end
        end
        RX_IDLE: if (!rxd_s) begin
          state_q <= RX_START;
          cnt_q   <= '0;
        end
        RX_START: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == MID) begin
            state_q <= rxd_s ? RX_IDLE : RX_DATA;
            cnt_q   <= '0;
            bit_q   <= '0;
          end
        end
        RX_DATA: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            cnt_q <= '0;
            sh_q  <= {rxd_s, sh_q[7:1]};
            bit_q <= bit_q + 1'b1;
            if (bit_q == 3'd7) state_q <= RX_STOP;
          end
        end
        RX_STOP: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            state_q <= rxd_s ? RX_IDLE : RX_UNARMED;
            valid_o <= rxd_s;
            data_o  <= sh_q;
          end
        end
        default: state_q <= RX_UNARMED;
      endcase
    end
endmodule

// File: rtl/miner_io_wrapper_uart_tx.sv
// uart_tx: sends a 32-bit word as four back-to-back 8N1 bytes, most significant byte first
module uart_tx
  import miner_io_wrapper_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [31:0] word_i,
  output logic        txd_o,
  output logic        busy_o,
  output logic        done_o
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  tx_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [1:0]    byte_q;
  logic [7:0]    sh_q;
  logic [23:0]   rest_q;
  assign busy_o = state_q != TX_IDLE;
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      sh_q    <= '0;
      rest_q  <= '0;
      txd_o   <= 1'b1;
      done_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      cnt_q  <= cnt_q + 1'b1;
      case (state_q)
        TX_IDLE: begin
          cnt_q <= '0;
          txd_o <= 1'b1;
          if (start_i) begin
            state_q <= TX_START;
            txd_o   <= 1'b0;
            sh_q    <= word_i[31:24];
            rest_q  <= word_i[23:0];
            byte_q  <= '0;
          end
        end
        TX_START: if (cnt_q == LAST) begin
          cnt_q   <= '0;
          state_q <= TX_DATA;
          bit_q   <= '0;
          txd_o   <= sh_q[0];
          sh_q    <= sh_q >> 1;
        end
        TX_DATA: if (cnt_q == LAST) begin
          cnt_q   <= '0;
          bit_q   <= bit_q + 1'b1;
          txd_o   <= bit_q == 3'd7 ? 1'b1 : sh_q[0];
          sh_q    <= sh_q >> 1;
          state_q <= bit_q == 3'd7 ? TX_STOP : TX_DATA;
        end
        TX_STOP: if (cnt_q == LAST) begin
          cnt_q  <= '0;
          done_o <= 1'b1;
          if (byte_q == 2'd3) state_q <= TX_IDLE;
          else begin
            state_q <= TX_START;
            txd_o   <= 1'b0;
            byte_q  <= byte_q + 1'b1;
            sh_q    <= rest_q[23:16];
            rest_q  <= {rest_q[15:0], 8'h00};
          end
        end
        default: state_q <= TX_IDLE;
      endcase
    end
endmodule

// File: rtl/miner_io_wrapper.sv
// miner_io_wrapper: UART-loaded nonce search with UART result report and hex display
module miner_io_wrapper
  import miner_io_wrapper_pkg::*;
#(
  parameter int CLKS_PER_BIT   = 868,
  parameter int REFRESH_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] ca,
  output logic [7:0] an,
  output logic       txd,
  input  logic       rxd,
  input  logic [2:0] display_toggle
);
  logic [31:0] nonce_q, target_q, rx_word_q, result_q, rx_word_d, disp;
  logic [7:0]  rx_count_q, tx_count_q, rx_data;
  logic        running_q, found_q, pend_q, rx_valid, tx_busy, tx_done, tx_start;
  assign rx_word_d = {rx_word_q[23:0], rx_data};
  assign tx_start  = pend_q && !tx_busy;
  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk(clk), .rst(reset), .rxd_i(rxd), .data_o(rx_data), .valid_o(rx_valid)
  );
  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk(clk), .rst(reset), .start_i(tx_start), .word_i(result_q),
    .txd_o(txd), .busy_o(tx_busy), .done_o(tx_done)
  );
  seg_mux #(.REFRESH_CYCLES(REFRESH_CYCLES)) u_seg (
    .clk(clk), .rst(reset), .value_i(disp), .ca_o(ca), .an_o(an)
  );
  always_ff @(posedge clk)
    if (reset) begin
      nonce_q    <= '0;
      target_q   <= '0;
      rx_word_q  <= '0;
      result_q   <= '0;
      rx_count_q <= '0;
      tx_count_q <= '0;
      running_q  <= 1'b0;
      found_q    <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      if (tx_done) tx_count_q <= tx_count_q + 1'b1;
      if (tx_start) pend_q <= 1'b0;
      if (running_q && nonce_q == target_q) begin
        found_q   <= 1'b1;
        running_q <= 1'b0;
        result_q  <= nonce_q;
        pend_q    <= 1'b1;
      end else if (running_q) nonce_q <= nonce_q + 32'd1;
      if (rx_valid) begin
        rx_word_q  <= rx_word_d;
        rx_count_q <= rx_count_q + 1'b1;
        if (rx_count_q[1:0] == 2'd3) begin
          target_q  <= rx_word_d;
          nonce_q   <= '0;
          found_q   <= 1'b0;
          running_q <= 1'b1;
        end
      end
    end
  always_comb
    disp = display_toggle >= DISP_ZERO    ? 32'h0 :
           display_toggle == DISP_NONCE   ? nonce_q :
           display_toggle == DISP_TARGET  ? target_q :
           display_toggle == DISP_RX_WORD ? rx_word_q :
           display_toggle == DISP_RESULT  ? result_q :
           display_toggle == DISP_COUNTS  ? {16'h0, rx_count_q, tx_count_q} :
           display_toggle == DISP_STATUS  ? {30'h0, found_q, running_q} : 32'h0;
endmodule

// File: tb/tb_miner_io_wrapper.sv
// tb_miner_io_wrapper: directed checks of UART load, nonce search, UART report and display
module tb_miner_io_wrapper;
  localparam int CPB = 4;
  localparam int REF = 16;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rxd = 1'b0;
  logic [2:0] display_toggle = 3'd0;
  logic [7:0] ca, an;
  logic       txd;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  logic [7:0] glyph [8];
  logic [7:0] glyph_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  miner_io_wrapper #(.CLKS_PER_BIT(CPB), .REFRESH_CYCLES(REF)) dut (
    .clk(clk), .reset(reset), .ca(ca), .an(an), .txd(txd), .rxd(rxd),
    .display_toggle(display_toggle)
  );
  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    hold(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      hold(CPB);
    end
    rxd = stop;
    hold(CPB);
  endtask
  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], 1'b1);
  endtask
  task automatic read_disp(input logic [2:0] sel, output logic [31:0] v);
    display_toggle = sel;
    v = 'x;
    for (int c = 0; c < 8 * REF; c++) begin
      @(negedge clk);
      for (int d = 0; d < 8; d++)
        if (an === ~(8'd1 << d)) begin
          glyph[d] = ca;
          for (int g = 0; g < 16; g++) if (glyph_tbl[g] === ca) v[d*4 +: 4] = g[3:0];
        end
    end
  endtask
  task automatic measure_run(output int n);
    int k = 0;
    n = 0;
    while (dut.running_q !== 1'b1 && k < 1000) begin @(negedge clk); k++; end
    while (dut.running_q === 1'b1 && n < 1000) begin @(negedge clk); n++; end
  endtask
  task automatic capture_frame(output logic [31:0] w, output int ferr);
    int t_prev, k;
    logic [7:0] b;
    w = 'x;
    ferr = 0;
    t_prev = 0;
    for (int j = 0; j < 4; j++) begin
      k = 0;
      while (txd !== 1'b0 && k < 400) begin @(negedge clk); k++; end
      if (k >= 400) begin
        n_cmp++; n_bad++;
        $display("FAIL tx_timeout: byte %0d never started, txd=%b required 0", j, txd);
        return;
      end
      if (j > 0 && cyc - t_prev != 10 * CPB) ferr++;
      t_prev = cyc;
      hold(CPB / 2);
      if (txd !== 1'b0) ferr++;
      for (int i = 0; i < 8; i++) begin
        hold(CPB);
        b[i] = txd;
      end
      hold(CPB);
      if (txd !== 1'b1) ferr++;
      w = {w[23:0], b};
    end
  endtask
  task automatic test_reset_break;
    int bad_tx = 0, bad_ca = 0, bad_an = 0;
    rxd = 1'b0; display_toggle = 3'd0; reset = 1'b1;
    hold(3);
    n_cmp++; if (txd !== 1'b1) begin n_bad++; $display("FAIL reset_txd: got %b, expected 1", txd); end
    n_cmp++; if (an !== 8'hFE) begin n_bad++; $display("FAIL reset_an: got %h, expected fe", an); end
    n_cmp++; if (ca !== 8'hC0) begin n_bad++; $display("FAIL reset_ca: got %h, expected c0", ca); end
    reset = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (txd !== 1'b1) bad_tx++;
      if (ca !== 8'hC0) bad_ca++;
      if (an !== ~(8'd1 << ((c / REF) % 8))) bad_an++;
      @(negedge clk);
    end
    n_cmp++; if (bad_tx != 0) begin n_bad++; $display("FAIL break_txd: %0d cycles not idle, expected 0", bad_tx); end
    n_cmp++; if (bad_ca != 0) begin n_bad++; $display("FAIL break_ca: %0d cycles not c0, expected 0", bad_ca); end
    n_cmp++; if (bad_an != 0) begin n_bad++; $display("FAIL break_an_scan: %0d cycles wrong anode, expected 0", bad_an); end
    n_cmp++; if (dut.rx_count_q !== 8'd0) begin n_bad++; $display("FAIL break_rx_count: got %0d, expected 0", dut.rx_count_q); end
  endtask
  task automatic test_target5;
    int n, ferr;
    logic [31:0] w;
    rxd = 1'b1;
    hold(20);
    send_word(32'h0000_0005);
    measure_run(n);
    n_cmp++; if (n != 6) begin n_bad++; $display("FAIL t5_run_cycles: got %0d, expected 6", n); end
    n_cmp++; if (dut.found_q !== 1'b1) begin n_bad++; $display("FAIL t5_found: got %b, expected 1", dut.found_q); end
    n_cmp++; if (dut.result_q !== 32'd5) begin n_bad++; $display("FAIL t5_result: got %h, expected 5", dut.result_q); end
    capture_frame(w, ferr);
    n_cmp++; if (w !== 32'd5) begin n_bad++; $display("FAIL t5_tx_word: got %h, expected 00000005", w); end
    n_cmp++; if (ferr != 0) begin n_bad++; $display("FAIL t5_tx_framing: %0d errors, expected 0", ferr); end
    hold(3 * CPB);
    n_cmp++; if (dut.tx_count_q !== 8'd4) begin n_bad++; $display("FAIL t5_tx_count: got %0d, expected 4", dut.tx_count_q); end
  endtask
  task automatic test_rx_word;
    logic [31:0] v;
    send_word(32'h1234_5678);
    hold(5);
    read_disp(3'd2, v);
    n_cmp++; if (v !== 32'h1234_5678) begin n_bad++; $display("FAIL disp_rx_word: got %h, expected 12345678", v); end
    n_cmp++; if (glyph[7] !== 8'hF9) begin n_bad++; $display("FAIL disp_digit7: got %h, expected f9", glyph[7]); end
    n_cmp++; if (glyph[0] !== 8'h80) begin n_bad++; $display("FAIL disp_digit0: got %h, expected 80", glyph[0]); end
    read_disp(3'd1, v);
    n_cmp++; if (v !== 32'h1234_5678) begin n_bad++; $display("FAIL disp_target: got %h, expected 12345678", v); end
    read_disp(3'd4, v);
    n_cmp++; if (v !== 32'h0000_0804) begin n_bad++; $display("FAIL disp_counts: got %h, expected 00000804", v); end
    read_disp(3'd5, v);
    n_cmp++; if (v !== 32'h0000_0001) begin n_bad++; $display("FAIL disp_status_run: got %h, expected 00000001", v); end
    read_disp(3'd6, v);
    n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL disp_zero: got %h, expected 00000000", v); end
  endtask
  task automatic test_framing;
    send_byte(8'hAA, 1'b0);
    hold(8);
    rxd = 1'b1;
    hold(2);
    send_byte(8'h00, 1'b1);
    n_cmp++; if (dut.rx_count_q !== 8'd8) begin n_bad++; $display("FAIL frame_discard: rx_count %0d, expected 8", dut.rx_count_q); end
    hold(10);
    send_byte(8'h9A, 1'b1);
    hold(3);
    n_cmp++; if (dut.rx_count_q !== 8'd9) begin n_bad++; $display("FAIL frame_rearm_count: got %0d, expected 9", dut.rx_count_q); end
    n_cmp++; if (dut.rx_word_q !== 32'h3456_789A) begin n_bad++; $display("FAIL frame_rearm_word: got %h, expected 3456789a", dut.rx_word_q); end
  endtask
  task automatic test_reset_mid;
    int k = 0;
    reset = 1'b1;
    hold(2);
    reset = 1'b0;
    rxd = 1'b1;
    hold(20);
    send_word(32'h0001_0000);
    while (dut.nonce_q !== 32'd1000 && k < 5000) begin @(negedge clk); k++; end
    n_cmp++; if (dut.nonce_q !== 32'd1000) begin n_bad++; $display("FAIL mid_nonce_reach: got %0d, expected 1000", dut.nonce_q); end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (dut.nonce_q !== 32'd0) begin n_bad++; $display("FAIL mid_nonce: got %0d, expected 0", dut.nonce_q); end
    n_cmp++; if (dut.running_q !== 1'b0) begin n_bad++; $display("FAIL mid_running: got %b, expected 0", dut.running_q); end
    n_cmp++; if (txd !== 1'b1) begin n_bad++; $display("FAIL mid_txd: got %b, expected 1", txd); end
    n_cmp++; if (an !== 8'hFE) begin n_bad++; $display("FAIL mid_an: got %h, expected fe", an); end
    reset = 1'b0;
  endtask
  task automatic test_zero;
    int n, ferr;
    logic [31:0] w, v;
    hold(20);
    send_word(32'h0);
    measure_run(n);
    n_cmp++; if (n != 1) begin n_bad++; $display("FAIL z_run_cycles: got %0d, expected 1", n); end
    capture_frame(w, ferr);
    n_cmp++; if (w !== 32'h0) begin n_bad++; $display("FAIL z_tx_word: got %h, expected 00000000", w); end
    n_cmp++; if (ferr != 0) begin n_bad++; $display("FAIL z_tx_framing: %0d errors, expected 0", ferr); end
    read_disp(3'd5, v);
    n_cmp++; if (v !== 32'h0000_0002) begin n_bad++; $display("FAIL z_disp_status: got %h, expected 00000002", v); end
  endtask
  initial begin
    @(negedge clk);
    test_reset_break;
    test_target5;
    test_rx_word;
    test_framing;
    test_reset_mid;
    test_zero;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
